// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display scanner.
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } estado_t;

   localparam int LARGURA_DIGITO = 2;
   localparam int NUM_DIGITOS    = 4;

   localparam logic [LARGURA_DIGITO-1:0] ULTIMO_DIGITO = LARGURA_DIGITO'(NUM_DIGITOS - 1);

endpackage

// File: rtl/contador_modulo.sv
// Wrapping up-counter; wraps to zero after the run-time value 'ultimo' or at MODULO-1,
// whichever comes first. 'terminal' flags the last count of the current run.
module contador_modulo #(
   parameter int LARGURA = 4,
   parameter int MODULO  = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               enable,
   input  logic [LARGURA-1:0] ultimo,
   output logic               terminal
);

   logic [LARGURA-1:0] r_contagem;
   logic               w_fim;

   assign w_fim    = (r_contagem == ultimo) || (r_contagem == LARGURA'(MODULO - 1));
   assign terminal = enable & w_fim;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_contagem <= '0;
      end else if (clear) begin
         r_contagem <= '0;
      end else if (enable) begin
         r_contagem <= w_fim ? '0 : r_contagem + LARGURA'(1);
      end
   end

endmodule

// File: rtl/controlador_varredura.sv
// Scan scheduler for a 4-digit multiplexed 7-seg display: SHOW/BLANK slots, frame-latched BCD.
// Optional macro BRILHO_PWM_EN adds a 4-bit brightness input that PWM-gates the SHOW interval.
module controlador_varredura
   import display_pkg::*;
#(
   parameter int DIV_DIGITO   = 12500,
   parameter int BLANK_CICLOS = 64
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      ligado,
`ifdef BRILHO_PWM_EN
   input  logic [3:0]                brilho,
`endif
   input  logic [3:0]                duzias_dezenas,
   input  logic [3:0]                duzias_unidades,
   input  logic [3:0]                rolhas_dezenas,
   input  logic [3:0]                rolhas_unidades,
   output logic [LARGURA_DIGITO-1:0] contador,
   output logic                      ligado_display,
   output logic [3:0]                dd_q,
   output logic [3:0]                du_q,
   output logic [3:0]                rd_q,
   output logic [3:0]                ru_q,
   output logic                      quadro,
   output logic [1:0]                estado_dbg
);

   localparam int MAX_PRE     = (DIV_DIGITO > BLANK_CICLOS) ? DIV_DIGITO : BLANK_CICLOS;
   localparam int LARGURA_PRE = (MAX_PRE > 1) ? $clog2(MAX_PRE) : 1;

   estado_t                   r_estado;
   logic [LARGURA_DIGITO-1:0] r_contador;
   logic                      r_ligado_display;
   logic                      r_quadro;
   logic [3:0]                r_dd, r_du, r_rd, r_ru;

   logic [LARGURA_PRE-1:0]    w_ultimo;
   logic                      w_terminal;
   logic                      w_clear;
   logic                      w_enable;
   logic                      w_captura;
   logic                      w_acende_inicio;
   logic                      w_acende_show;

   assign w_clear  = ~ligado | (r_estado == ST_IDLE);
   assign w_enable = (r_estado == ST_SHOW) | (r_estado == ST_BLANK);
   assign w_ultimo = (r_estado == ST_SHOW) ? LARGURA_PRE'(DIV_DIGITO - 1)
                                           : LARGURA_PRE'(BLANK_CICLOS - 1);

   // A frame is latched on enable and when the digit select wraps 3->0 entering BLANK.
   assign w_captura = ligado & ((r_estado == ST_IDLE) |
                      ((r_estado == ST_SHOW) & w_terminal & (r_contador == ULTIMO_DIGITO)));

   contador_modulo #(
      .LARGURA (LARGURA_PRE),
      .MODULO  (MAX_PRE)
   ) u_prescaler (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (w_clear),
      .enable   (w_enable),
      .ultimo   (w_ultimo),
      .terminal (w_terminal)
   );

`ifdef BRILHO_PWM_EN
   logic [3:0] r_pwm;
   logic [3:0] w_pwm_prox;
   logic       w_entra_show;

   assign w_pwm_prox      = r_pwm + 4'd1;
   assign w_entra_show    = ligado & ((r_estado == ST_IDLE) | ((r_estado == ST_BLANK) & w_terminal));
   // The registered enable is computed for the pwm value the next SHOW cycle will hold.
   assign w_acende_inicio = (brilho != 4'd0);
   assign w_acende_show   = (brilho == 4'hF) | (w_pwm_prox < brilho);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pwm <= '0;
      end else if (w_entra_show) begin
         r_pwm <= '0;
      end else if (r_estado == ST_SHOW) begin
         r_pwm <= w_pwm_prox;
      end
   end
`else
   assign w_acende_inicio = 1'b1;
   assign w_acende_show   = 1'b1;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_estado         <= ST_IDLE;
         r_contador       <= '0;
         r_ligado_display <= 1'b0;
         r_quadro         <= 1'b0;
         r_dd             <= '0;
         r_du             <= '0;
         r_rd             <= '0;
         r_ru             <= '0;
      end else begin
         r_quadro <= w_captura;
         if (w_captura) begin
            r_dd <= duzias_dezenas;
            r_du <= duzias_unidades;
            r_rd <= rolhas_dezenas;
            r_ru <= rolhas_unidades;
         end
         if (!ligado) begin
            r_estado         <= ST_IDLE;
            r_contador       <= '0;
            r_ligado_display <= 1'b0;
         end else begin
            case (r_estado)
               ST_IDLE: begin
                  r_estado         <= ST_SHOW;
                  r_contador       <= '0;
                  r_ligado_display <= w_acende_inicio;
               end
               ST_SHOW: begin
                  if (w_terminal) begin
                     r_estado         <= ST_BLANK;
                     r_contador       <= r_contador + LARGURA_DIGITO'(1);
                     r_ligado_display <= 1'b0;
                  end else begin
                     r_ligado_display <= w_acende_show;
                  end
               end
               ST_BLANK: begin
                  if (w_terminal) begin
                     r_estado         <= ST_SHOW;
                     r_ligado_display <= w_acende_inicio;
                  end else begin
                     r_ligado_display <= 1'b0;
                  end
               end
               default: begin
                  r_estado         <= ST_IDLE;
                  r_contador       <= '0;
                  r_ligado_display <= 1'b0;
               end
            endcase
         end
      end
   end

   assign contador       = r_contador;
   assign ligado_display = r_ligado_display;
   assign quadro         = r_quadro;
   assign dd_q           = r_dd;
   assign du_q           = r_du;
   assign rd_q           = r_rd;
   assign ru_q           = r_ru;
   assign estado_dbg     = r_estado;

endmodule

// File: tb/tb_controlador_varredura.sv
// Self-checking bench for controlador_varredura; slot-arithmetic model plus a snapshot queue.
// Builds with or without BRILHO_PWM_EN (the brightness scenario runs only when it is defined).
module tb_controlador_varredura;

`ifdef BRILHO_PWM_EN
   localparam int DIV = 32;
`else
   localparam int DIV = 8;
`endif
   localparam int BLK   = 2;
   localparam int SLOT  = DIV + BLK;
   localparam int FRAME = 4 * SLOT;

   logic        clock;
   logic        reset_n;
   logic        ligado;
   logic [3:0]  b_dd, b_du, b_rd, b_ru;
   logic [1:0]  contador;
   logic        ligado_display;
   logic [3:0]  dd_q, du_q, rd_q, ru_q;
   logic        quadro;
   logic [1:0]  estado_dbg;
`ifdef BRILHO_PWM_EN
   logic [3:0]  brilho;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   controlador_varredura #(
      .DIV_DIGITO   (DIV),
      .BLANK_CICLOS (BLK)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .ligado          (ligado),
`ifdef BRILHO_PWM_EN
      .brilho          (brilho),
`endif
      .duzias_dezenas  (b_dd),
      .duzias_unidades (b_du),
      .rolhas_dezenas  (b_rd),
      .rolhas_unidades (b_ru),
      .contador        (contador),
      .ligado_display  (ligado_display),
      .dd_q            (dd_q),
      .du_q            (du_q),
      .rd_q            (rd_q),
      .ru_q            (ru_q),
      .quadro          (quadro),
      .estado_dbg      (estado_dbg)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: position inside the running scan, derived from cycles since enable
   logic [15:0] exp_q[$];
   logic [15:0] cur_snap = '0;
   bit          m_on     = 1'b0;
   int          m_t      = 0;
   logic [1:0]  e_cont   = '0;
   logic        e_disp   = 1'b0;
   logic        e_quadro = 1'b0;
   logic [1:0]  e_est    = 2'd0;

   always @(posedge clock or negedge reset_n) begin : model
      int pos;
      int slot;
      if (!reset_n) begin
         m_on = 1'b0; m_t = 0;
         e_cont = '0; e_disp = 1'b0; e_quadro = 1'b0; e_est = 2'd0;
         exp_q.delete();
      end else if (!ligado) begin
         m_on = 1'b0; m_t = 0;
         e_cont = '0; e_disp = 1'b0; e_quadro = 1'b0; e_est = 2'd0;
      end else begin
         if (!m_on) begin
            m_on = 1'b1;
            m_t  = 0;
         end else begin
            m_t++;
         end
         pos  = m_t % SLOT;
         slot = m_t / SLOT;
         e_quadro = (m_t == 0) || (pos == DIV && (slot % 4) == 3);
         if (e_quadro) exp_q.push_back({b_dd, b_du, b_rd, b_ru});
         e_cont = (pos < DIV) ? 2'(slot % 4) : 2'((slot + 1) % 4);
         e_est  = (pos < DIV) ? 2'd1 : 2'd2;
`ifdef BRILHO_PWM_EN
         e_disp = (pos < DIV) && ((brilho == 4'hF) || ((pos % 16) < int'(brilho)));
`else
         e_disp = (pos < DIV);
`endif
      end
   end

   // scoreboard: compare every cycle, pop a snapshot whenever the DUT announces a frame
   always @(negedge clock) begin : monitor
      if (!reset_n) cur_snap = '0;
      chk("contador", 32'(contador), 32'(e_cont));
      chk("ligado_display", 32'(ligado_display), 32'(e_disp));
      chk("quadro", 32'(quadro), 32'(e_quadro));
      chk("estado", 32'(estado_dbg), 32'(e_est));
      if (quadro === 1'b1) begin
         if (exp_q.size() == 0) chk("quadro_sem_snapshot", 32'(1), 32'(0));
         else cur_snap = exp_q.pop_front();
      end
      chk("snapshot", 32'({dd_q, du_q, rd_q, ru_q}), 32'(cur_snap));
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic wait_show_digit(input int dig, input int min_pos, input int max_pos);
      bit hit = 1'b0;
      for (int k = 0; k < 4 * FRAME && !hit; k++) begin
         tick(1);
         if (m_on && ((m_t / SLOT) % 4) == dig && (m_t % SLOT) >= min_pos && (m_t % SLOT) <= max_pos)
            hit = 1'b1;
      end
      if (!hit) chk("timeout_wait", 32'(0), 32'(1));
   endtask

   task automatic set_bcd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d);
      b_dd = a; b_du = b; b_rd = c; b_ru = d;
   endtask

   initial begin
      reset_n = 1'b0;
      ligado  = 1'b0;
`ifdef BRILHO_PWM_EN
      brilho  = 4'hF;
`endif
      set_bcd(4'd1, 4'd2, 4'd3, 4'd4);
      tick(3);
      reset_n = 1'b1;
      tick(3);

      // first enable, then change inputs mid-frame: snapshot must hold until the wrap
      ligado = 1'b1;
      tick(15);
      set_bcd(4'd9, 4'd9, 4'd9, 4'd9);
      tick(FRAME + 10);

      // drop enable during the SHOW slot of digit 2
      wait_show_digit(2, 1, DIV - 2);
      ligado = 1'b0;
      tick(3);
      set_bcd(4'd5, 4'd6, 4'd7, 4'd8);
      ligado = 1'b1;
      tick(SLOT + 3);

      // drop enable exactly at a SHOW terminal count
      wait_show_digit(1, DIV - 1, DIV - 1);
      ligado = 1'b0;
      tick(2);
      ligado = 1'b1;

      // random BCD (including non-decimal codes) changing at random points
      for (int f = 0; f < 6; f++) begin
         set_bcd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         tick($urandom_range(5, FRAME));
      end

      // asynchronous reset between edges while in BLANK
      wait_show_digit(2, DIV, SLOT - 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_contador", 32'(contador), 32'(0));
      chk("async_ligado_display", 32'(ligado_display), 32'(0));
      chk("async_quadro", 32'(quadro), 32'(0));
      chk("async_snapshot", 32'({dd_q, du_q, rd_q, ru_q}), 32'(0));
      chk("async_estado", 32'(estado_dbg), 32'(0));
      tick(2);
      reset_n = 1'b1;
      tick(FRAME + 5);

`ifdef BRILHO_PWM_EN
      brilho = 4'd4;
      tick(2 * FRAME);
      brilho = 4'hF;
      tick(FRAME);
      brilho = 4'd0;
      tick(FRAME);
      brilho = 4'($urandom_range(1, 14));
      tick(FRAME);
`endif

      ligado = 1'b0;
      tick(3);
      @(negedge clock);
      #1;
      chk("fila_vazia", 32'(exp_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
